// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Parametrised inter-stage pipeline register. Carries an opaque DATA_W-bit
//   stage bundle from one pipeline stage to the next with a valid/ready
//   handshake and a synchronous flush. With SKID=1 a second (skid) entry lets
//   in_ready come straight from the state flop, so the downstream stall does
//   not propagate combinationally to the upstream stage.
//
// Parameters
//   DATA_W   width of the stage bundle (>=1)
//   BUBBLE   value shown on out_data whenever the stage is empty (NOP bundle)
//   SKID     0: single register, in_ready = !out_valid | out_ready
//            1: two entries (main M + skid S), in_ready = (state != TWO)
//
// Ports
//   clk          clock, all state on posedge
//   rst          asynchronous, active-low reset
//   flush        synchronous flush, kills every held entry
//   in_valid     upstream bundle valid
//   in_ready     stage can accept in_data this cycle
//   in_data      upstream bundle
//   out_valid    out_data holds a live bundle
//   out_ready    downstream consumes out_data this cycle
//   out_data     bundle to next stage, BUBBLE when out_valid=0
//   occ          number of entries held (0..2)
//   o_dbg_state  raw FSM state (EMPTY=0, ONE/FULL=1, TWO=2)
//
// Handshake: a transfer happens on a posedge where valid & ready are both 1
// on that side. A producer holding valid keeps its data stable until the
// transfer; ready may depend on the current state (and, for SKID=0, on
// out_ready) but never on in_valid or in_data.

module pipe_stage_buf #(
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter bit                SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [1:0]        o_dbg_state
);

  // ST_ONE doubles as FULL in single-register mode; ST_TWO is only reachable
  // with SKID=1.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_fire_in;
  logic              w_fire_out;

  // State encoding equals the entry count, so occ is the state itself.
  assign occ         = r_state;
  assign o_dbg_state = r_state;
  assign out_valid   = (r_state != ST_EMPTY);
  // Empty entries are kept at BUBBLE, so M drives out_data directly.
  assign out_data    = r_main;

  always_comb begin
    if (SKID) begin
      in_ready = (r_state != ST_TWO);
    end else begin
      in_ready = (r_state == ST_EMPTY) | out_ready;
    end
  end

  assign w_fire_in  = in_valid & in_ready;
  assign w_fire_out = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Overrides every transition; an accepted input this cycle is dropped.
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_fire_in) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_fire_in && w_fire_out) begin
            w_main_nxt = in_data;
          end else if (w_fire_out) begin
            w_main_nxt  = BUBBLE;
            w_state_nxt = ST_EMPTY;
          end else if (w_fire_in) begin
            if (SKID) begin
              w_skid_nxt  = in_data;
              w_state_nxt = ST_TWO;
            end else begin
              // Unreachable: SKID=0 only accepts when full if out_ready=1.
              w_main_nxt = in_data;
            end
          end
        end
        ST_TWO: begin
          // in_ready=0 here, so only the drain of M can happen.
          if (out_ready) begin
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE;
          w_skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE;
      r_skid  <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int          W   = 8;
  localparam logic [W-1:0] BUB = 8'hEE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic         s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [W-1:0] s1_in_data, s1_out_data;
  logic [1:0]   s1_occ, s1_dbg;
  // SKID=0 instance signals
  logic         s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [W-1:0] s0_in_data, s0_out_data;
  logic [1:0]   s0_occ, s0_dbg;

  pipe_stage_buf #(.DATA_W(W), .BUBBLE(BUB), .SKID(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(s1_flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
    .occ(s1_occ), .o_dbg_state(s1_dbg)
  );

  pipe_stage_buf #(.DATA_W(W), .BUBBLE(BUB), .SKID(1'b0)) u_reg (
    .clk(clk), .rst(rst), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .occ(s0_occ), .o_dbg_state(s0_dbg)
  );

  // ---------------- counters / checker ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_s1(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    s1_in_valid  = iv;
    s1_in_data   = d;
    s1_out_ready = ordy;
    s1_flush     = fl;
  endtask

  task automatic drive_s0(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    s0_in_valid  = iv;
    s0_in_data   = d;
    s0_out_ready = ordy;
    s0_flush     = fl;
  endtask

  // ---------------- vector table (SKID=1) ----------------
  // Each row: inputs driven for one cycle, expected outputs seen before the
  // following posedge (i.e. the state left by the previous rows).
  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic [1:0]   e_occ;
    logic         e_ir;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl,
                     input logic e_ov, input logic [W-1:0] e_od, input logic [1:0] e_occ,
                     input logic e_ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir;
    tbl.push_back(v);
  endtask

  // ---------------- scoreboards for random phase ----------------
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic         iv, ordy, fl, e_ov, e_ir, fi, fo;
    logic [W-1:0] d, e_od;

    drive_s1(1'b0, '0, 1'b0, 1'b0);
    drive_s0(1'b0, '0, 1'b0, 1'b0);

    // Stream 0x1..0x8 back to back, then drain.
    for (int i = 1; i <= 8; i++)
      add(1'b1, W'(i), 1'b1, 1'b0, (i > 1), (i > 1) ? W'(i - 1) : BUB,
          (i > 1) ? 2'd1 : 2'd0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08, 2'd1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1);
    // Backpressure: 0x11,0x22 fill both entries, 0x33 waits for in_ready.
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1);
    add(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1);
    add(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2, 1'b0);
    add(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 2'd2, 1'b0);
    add(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1);
    // Flush from TWO (0x5,0x6) with 0x7 offered.
    add(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1);
    add(1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h05, 2'd1, 1'b1);
    add(1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h05, 2'd2, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1);
    // Flush from ONE while both sides fire: 0x9 still seen, 0x7 dropped.
    add(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1);
    add(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h09, 2'd1, 1'b1);
    add(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, BUB,   2'd0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_s1_ov",  {31'b0, s1_out_valid}, 32'd0);
    chk("rst_s1_od",  {24'b0, s1_out_data},  {24'b0, BUB});
    chk("rst_s1_occ", {30'b0, s1_occ},       32'd0);
    chk("rst_s1_ir",  {31'b0, s1_in_ready},  32'd1);
    chk("rst_s1_dbg", {30'b0, s1_dbg},       32'd0);
    chk("rst_s0_ov",  {31'b0, s0_out_valid}, 32'd0);
    chk("rst_s0_od",  {24'b0, s0_out_data},  {24'b0, BUB});
    chk("rst_s0_ir",  {31'b0, s0_in_ready},  32'd1);
    chk("rst_s0_dbg", {30'b0, s0_dbg},       32'd0);
    rst = 1'b1;

    // Table-driven vectors
    foreach (tbl[i]) begin
      @(negedge clk);
      drive_s1(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      #1;
      chk($sformatf("v%0d_ov", i),  {31'b0, s1_out_valid}, {31'b0, tbl[i].e_ov});
      chk($sformatf("v%0d_od", i),  {24'b0, s1_out_data},  {24'b0, tbl[i].e_od});
      chk($sformatf("v%0d_occ", i), {30'b0, s1_occ},       {30'b0, tbl[i].e_occ});
      chk($sformatf("v%0d_ir", i),  {31'b0, s1_in_ready},  {31'b0, tbl[i].e_ir});
    end

    // Async reset while holding two entries (0xA, 0xB)
    @(negedge clk); drive_s1(1'b1, 8'h0A, 1'b0, 1'b0);
    @(negedge clk); drive_s1(1'b1, 8'h0B, 1'b0, 1'b0);
    @(negedge clk); drive_s1(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("two_occ",  {30'b0, s1_occ},      32'd2);
    chk("two_od",   {24'b0, s1_out_data}, 32'h0A);
    #1 rst = 1'b0;
    #1;
    chk("arst_ov",  {31'b0, s1_out_valid}, 32'd0);
    chk("arst_od",  {24'b0, s1_out_data},  {24'b0, BUB});
    chk("arst_occ", {30'b0, s1_occ},       32'd0);
    chk("arst_ir",  {31'b0, s1_in_ready},  32'd1);
    @(negedge clk); rst = 1'b1;

    // SKID=0: full with 0x40, simultaneous consume + accept of 0x41
    @(negedge clk); drive_s0(1'b1, 8'h40, 1'b0, 1'b0);
    @(negedge clk); drive_s0(1'b1, 8'h41, 1'b0, 1'b0);
    #1;
    chk("s0_full_ir",  {31'b0, s0_in_ready}, 32'd0);
    chk("s0_full_od",  {24'b0, s0_out_data}, 32'h40);
    chk("s0_full_occ", {30'b0, s0_occ},      32'd1);
    #1 s0_out_ready = 1'b1;
    #1;
    chk("s0_comb_ir",  {31'b0, s0_in_ready}, 32'd1);
    @(negedge clk); drive_s0(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("s0_next_od",  {24'b0, s0_out_data},  32'h41);
    chk("s0_next_ov",  {31'b0, s0_out_valid}, 32'd1);
    @(negedge clk); drive_s0(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("s0_drain_ov", {31'b0, s0_out_valid}, 32'd0);
    chk("s0_drain_od", {24'b0, s0_out_data},  {24'b0, BUB});

    // Random phase: same stimulus to both instances, independent models.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      fl   = ($urandom_range(0, 99) < 3);
      d    = W'($urandom_range(0, 255));
      drive_s1(iv, d, ordy, fl);
      drive_s0(iv, d, ordy, fl);
      #1;
      // SKID=1 model
      e_ov = (exp_q1.size() != 0);
      e_od = e_ov ? exp_q1[0] : BUB;
      e_ir = (exp_q1.size() < 2);
      chk("rnd1_ov",  {31'b0, s1_out_valid}, {31'b0, e_ov});
      chk("rnd1_od",  {24'b0, s1_out_data},  {24'b0, e_od});
      chk("rnd1_occ", {30'b0, s1_occ},       exp_q1.size());
      chk("rnd1_ir",  {31'b0, s1_in_ready},  {31'b0, e_ir});
      fi = iv & e_ir;
      fo = e_ov & ordy;
      if (fl) exp_q1.delete();
      else begin
        if (fo) void'(exp_q1.pop_front());
        if (fi) exp_q1.push_back(d);
      end
      // SKID=0 model
      e_ov = (exp_q0.size() != 0);
      e_od = e_ov ? exp_q0[0] : BUB;
      e_ir = !e_ov | ordy;
      chk("rnd0_ov",  {31'b0, s0_out_valid}, {31'b0, e_ov});
      chk("rnd0_od",  {24'b0, s0_out_data},  {24'b0, e_od});
      chk("rnd0_occ", {30'b0, s0_occ},       exp_q0.size());
      chk("rnd0_ir",  {31'b0, s0_in_ready},  {31'b0, e_ir});
      fi = iv & e_ir;
      fo = e_ov & ordy;
      if (fl) exp_q0.delete();
      else begin
        if (fo) void'(exp_q0.pop_front());
        if (fi) exp_q0.push_back(d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
